// File: rtl/dmem_seq_pkg.sv
// Shared definitions for the data-memory transfer sequencer: op codes, memory
// select codes, FSM state encoding and default widths.
package dmem_seq_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int ADDR_DMEM  = 8;

    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_WRITE = 2'b01,
        OP_READ  = 2'b10,
        OP_RW    = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        SEL_IDLE = 2'b00,
        SEL_V    = 2'b10,
        SEL_H    = 2'b11
    } sel_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    function automatic logic [1:0] dir_sel(input logic dir);
        return dir ? SEL_H : SEL_V;
    endfunction

    function automatic logic op_writes(input op_e op);
        return (op == OP_WRITE) || (op == OP_RW);
    endfunction

    function automatic logic op_reads(input op_e op);
        return (op == OP_READ) || (op == OP_RW);
    endfunction

endpackage

// File: rtl/dmem_seq_if.sv
// Command channel plus memory-side controls of the data-memory sequencer.
// The master drives commands and stall; the slave (sequencer) drives the rest.
interface dmem_seq_if
    import dmem_seq_pkg::*;
#(
    parameter int AddrDMEM = ADDR_DMEM
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic [1:0]          cmd_op;
    logic                cmd_dir;
    logic [AddrDMEM-1:0] cmd_rbase;
    logic [AddrDMEM-1:0] cmd_wbase;
    logic [AddrDMEM:0]   cmd_len;
    logic                stall;

    logic [AddrDMEM-1:0] r_addr;
    logic [AddrDMEM-1:0] w_addr;
    logic                we_ram;
    logic [1:0]          sel_ram_i;
    logic [1:0]          sel_ram_o;
    logic                out_valid;
    logic                busy;
    logic                done;

    modport master (
        output cmd_valid, cmd_op, cmd_dir, cmd_rbase, cmd_wbase, cmd_len, stall,
        input  cmd_ready, r_addr, w_addr, we_ram, sel_ram_i, sel_ram_o,
               out_valid, busy, done
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_dir, cmd_rbase, cmd_wbase, cmd_len, stall,
        output cmd_ready, r_addr, w_addr, we_ram, sel_ram_i, sel_ram_o,
               out_valid, busy, done
    );

endinterface

// File: rtl/dmem_seq.sv
// Data-memory transfer sequencer: streams len words into and/or out of the data
// memory from captured base addresses, with stall support and a done pulse.
//
//   state | meaning
//   IDLE  | waiting for a command, cmd_ready high
//   RUN   | one word per non-stalled cycle, addresses advance
//   DONE  | one-cycle completion pulse, memory controls idle
module dmem_seq
    import dmem_seq_pkg::*;
#(
    parameter int DataWidth = DATA_WIDTH,
    parameter int AddrDMEM  = ADDR_DMEM
) (
    input  logic        clk,
    input  logic        rst,
    dmem_seq_if.slave   bus
);

    if (DataWidth < 1 || AddrDMEM < 1) begin : g_param_check
        $error("dmem_seq: DataWidth and AddrDMEM must be positive");
    end

    localparam logic [AddrDMEM:0]   CntOne  = 1;
    localparam logic [AddrDMEM-1:0] AddrOne = 1;

    state_e              state_q;
    state_e              state_d;

    op_e                 op_q;
    logic                dir_q;
    logic [AddrDMEM:0]   len_q;
    logic [AddrDMEM:0]   cnt_q;
    logic [AddrDMEM-1:0] r_addr_q;
    logic [AddrDMEM-1:0] w_addr_q;

    logic accept;
    logic go_run;
    logic active;
    logic last;

    assign accept = (state_q == ST_IDLE) && bus.cmd_valid;
    assign go_run = accept && (bus.cmd_op != OP_NOP) && (bus.cmd_len != '0);
    assign active = (state_q == ST_RUN) && !bus.stall;
    assign last   = active && (cnt_q == (len_q - CntOne));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = go_run ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                if (last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Addresses load only when a real transfer starts, so a NOP or len=0
    // command leaves the previous addresses visible. The final word does not
    // advance them, keeping the last-used address on the bus afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= OP_NOP;
            dir_q    <= 1'b0;
            len_q    <= '0;
            cnt_q    <= '0;
            r_addr_q <= '0;
            w_addr_q <= '0;
        end else begin
            if (accept) begin
                op_q  <= op_e'(bus.cmd_op);
                dir_q <= bus.cmd_dir;
                len_q <= bus.cmd_len;
                cnt_q <= '0;
            end else if (active && !last) begin
                cnt_q <= cnt_q + CntOne;
            end

            if (go_run) begin
                r_addr_q <= bus.cmd_rbase;
                w_addr_q <= bus.cmd_wbase;
            end else if (active && !last) begin
                r_addr_q <= r_addr_q + AddrOne;
                w_addr_q <= w_addr_q + AddrOne;
            end
        end
    end

    always_comb begin
        bus.cmd_ready = (state_q == ST_IDLE);
        bus.busy      = (state_q != ST_IDLE);
        bus.done      = (state_q == ST_DONE);
        bus.r_addr    = r_addr_q;
        bus.w_addr    = w_addr_q;
        bus.we_ram    = 1'b0;
        bus.out_valid = 1'b0;
        bus.sel_ram_i = SEL_IDLE;
        bus.sel_ram_o = SEL_IDLE;
        if (state_q == ST_RUN) begin
            if (op_writes(op_q)) begin
                bus.we_ram    = active;
                bus.sel_ram_i = dir_sel(dir_q);
            end
            // RW reads out through the port opposite the write port
            if (op_reads(op_q)) begin
                bus.out_valid = active;
                bus.sel_ram_o = (op_q == OP_RW) ? dir_sel(!dir_q) : dir_sel(dir_q);
            end
        end
    end

endmodule

// File: tb/tb_dmem_seq.sv
// Scoreboard bench for dmem_seq: stimulus pushes expected writes, reads and done
// pulses; a negedge monitor pops and compares whenever the DUT presents one.
module tb_dmem_seq;
    import dmem_seq_pkg::*;

    localparam int AW = 8;

    typedef struct {
        int            cyc;
        logic [AW-1:0] addr;
        logic [1:0]    sel;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dmem_seq_if #(.AddrDMEM(AW)) bus ();

    dmem_seq #(.DataWidth(16), .AddrDMEM(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t wq[$];
    exp_t rq[$];
    int   dq[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        exp_t e;
        if (bus.we_ram === 1'b1) begin
            if (wq.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_write at cycle %0d: w_addr %0h", cyc, bus.w_addr);
            end else begin
                e = wq.pop_front();
                chk("write_cycle", cyc, e.cyc);
                chk("w_addr", bus.w_addr, e.addr);
                chk("sel_ram_i", bus.sel_ram_i, e.sel);
            end
        end
        if (bus.out_valid === 1'b1) begin
            if (rq.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_read at cycle %0d: r_addr %0h", cyc, bus.r_addr);
            end else begin
                e = rq.pop_front();
                chk("read_cycle", cyc, e.cyc);
                chk("r_addr", bus.r_addr, e.addr);
                chk("sel_ram_o", bus.sel_ram_o, e.sel);
            end
        end
        if (bus.done === 1'b1) begin
            if (dq.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_done at cycle %0d", cyc);
            end else begin
                chk("done_cycle", cyc, dq.pop_front());
                chk("done_idle_ctl", {bus.we_ram, bus.out_valid, bus.sel_ram_i, bus.sel_ram_o}, 0);
                chk("done_busy", bus.busy, 1);
            end
        end
    end

    task automatic drain(input string name);
        int t = 0;
        while ((wq.size() != 0 || rq.size() != 0 || dq.size() != 0) && t < 600) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (t >= 600) begin
            errors++;
            $display("FAIL %s_timeout: pending w=%0d r=%0d d=%0d expected all 0",
                     name, wq.size(), rq.size(), dq.size());
            wq.delete(); rq.delete(); dq.delete();
        end
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic dir, input logic [AW-1:0] rb,
                           input logic [AW-1:0] wb, input logic [AW:0] len,
                           input logic [15:0] stall_mask);
        int         a;
        int         i;
        int         j;
        int         n;
        int         done_words;
        logic       w_en;
        logic       r_en;
        logic       st;
        logic [1:0] si;
        logic [1:0] so;
        @(negedge clk);
        chk("cmd_ready_idle", bus.cmd_ready, 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_dir   = dir;
        bus.cmd_rbase = rb;
        bus.cmd_wbase = wb;
        bus.cmd_len   = len;
        a    = cyc + 1;
        w_en = op[0];
        r_en = op[1];
        si   = dir ? 2'b11 : 2'b10;
        so   = (op == 2'b11) ? (dir ? 2'b10 : 2'b11) : si;
        n    = (op == 2'b00) ? 0 : int'(len);
        i = 0;
        j = 0;
        while (i < n) begin
            st = (j < 16) ? stall_mask[j] : 1'b0;
            if (!st) begin
                if (w_en) wq.push_back('{a + j, AW'(wb + i), si});
                if (r_en) rq.push_back('{a + j, AW'(rb + i), so});
                i++;
            end
            j++;
        end
        dq.push_back(a + j);
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        done_words = 0;
        for (int k = 0; k < j; k++) begin
            st = (k < 16) ? stall_mask[k] : 1'b0;
            bus.stall = st;
            if (st) begin
                @(negedge clk);
                chk("stall_ctl", {bus.we_ram, bus.out_valid}, 0);
                chk("stall_sel_i", bus.sel_ram_i, w_en ? si : 2'b00);
                chk("stall_sel_o", bus.sel_ram_o, r_en ? so : 2'b00);
                if (r_en) chk("stall_r_addr", bus.r_addr, AW'(rb + done_words));
                if (w_en) chk("stall_w_addr", bus.w_addr, AW'(wb + done_words));
            end else begin
                done_words++;
            end
            @(posedge clk);
            #1;
        end
        bus.stall = 1'b0;
        drain("transfer");
    endtask

    initial begin
        int a;
        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_dir   = 1'b0;
        bus.cmd_rbase = '0;
        bus.cmd_wbase = '0;
        bus.cmd_len   = '0;
        bus.stall     = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", bus.cmd_ready, 1);
        chk("rst_busy_done", {bus.busy, bus.done}, 0);
        chk("rst_ctl", {bus.we_ram, bus.out_valid, bus.sel_ram_i, bus.sel_ram_o}, 0);
        chk("rst_addr", {bus.r_addr, bus.w_addr}, 0);
        rst = 1'b0;

        // WRITE vertical, 4 words from 0x10
        run_cmd(2'b01, 1'b0, 8'h00, 8'h10, 9'd4, 16'h0000);
        // READ horizontal from 0xFE, stall on 2nd RUN cycle, wraps past 0xFF
        run_cmd(2'b10, 1'b1, 8'hFE, 8'h00, 9'd4, 16'h0002);
        // RW vertical-in / horizontal-out
        run_cmd(2'b11, 1'b0, 8'h20, 8'h40, 9'd3, 16'h0000);

        // len=0 WRITE: done one cycle after acceptance; command during DONE ignored
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'b01;
        bus.cmd_dir   = 1'b1;
        bus.cmd_wbase = 8'h55;
        bus.cmd_len   = 9'd0;
        a = cyc + 1;
        dq.push_back(a);
        @(posedge clk);
        #1;
        bus.cmd_op    = 2'b10;
        bus.cmd_rbase = 8'h77;
        bus.cmd_len   = 9'd5;
        @(negedge clk);
        chk("busy_cmd_ready", bus.cmd_ready, 0);
        chk("len0_w_addr_held", bus.w_addr, 8'h42);
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        @(negedge clk);
        chk("len0_idle_busy", bus.busy, 0);
        chk("len0_r_addr_held", bus.r_addr, 8'h22);
        repeat (6) @(negedge clk);
        drain("len0");

        // RW horizontal-in / vertical-out with two stalls, write address wraps
        run_cmd(2'b11, 1'b1, 8'h05, 8'hFD, 9'd5, 16'h000A);
        // NOP with nonzero length completes immediately
        run_cmd(2'b00, 1'b0, 8'h00, 8'h00, 9'd3, 16'h0000);
        // full-depth WRITE covers every address once
        run_cmd(2'b01, 1'b1, 8'h00, 8'hF0, 9'd256, 16'h0000);

        // reset on the 3rd RUN cycle of a len=8 WRITE
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'b01;
        bus.cmd_dir   = 1'b0;
        bus.cmd_wbase = 8'h30;
        bus.cmd_len   = 9'd8;
        a = cyc + 1;
        for (int k = 0; k < 3; k++) wq.push_back('{a + k, AW'(8'h30 + k), 2'b10});
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_ctl", {bus.we_ram, bus.out_valid, bus.sel_ram_i, bus.sel_ram_o}, 0);
        chk("abort_busy_done", {bus.busy, bus.done}, 0);
        chk("abort_ready", bus.cmd_ready, 1);
        chk("abort_addr", {bus.r_addr, bus.w_addr}, 0);
        repeat (5) @(negedge clk);
        drain("abort");
        run_cmd(2'b01, 1'b0, 8'h00, 8'h60, 9'd2, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
